sd_spi: RTL and testbench

SD_SPI -- requirements
Module: sd_spi

---
 rtl/sd_spi.sv | 212 +++++++++++++++++++++
 tb/tb_sd_spi.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_spi.sv
// SD card SPI master: mode 0, MSB first, programmable SCLK divider.
// Register map on the IO bus: 0 = DATA, 1 = CTRL/STATUS, 2 = DIV.
// Optional feature macro SD_SPI_IRQ_EN: when defined, CTRL[2] is a
// writable interrupt enable and interrupt = done & ie. When undefined,
// interrupt is tied low and CTRL[2] reads zero.
module sd_spi #(
  parameter logic [7:0] RESET_DIV = 8'd63
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] io_addr,
  input  logic       io_write,
  input  logic       io_read,
  input  logic [7:0] io_wdata,
  output logic [7:0] io_rdata,
  output logic       interrupt,
  output logic       sclk,
  output logic       mosi,
  output logic       cs_n,
  input  logic       miso
);

  localparam logic [3:0] ADDR_DATA = 4'd0;
  localparam logic [3:0] ADDR_CTRL = 4'd1;
  localparam logic [3:0] ADDR_DIV  = 4'd2;

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_t;

  state_t     r_state;
  state_t     w_nextState;

  logic [7:0] r_div;
  logic [7:0] r_cnt;
  logic       r_sclk;
  logic [2:0] r_bitCnt;
  logic [7:0] r_tx;
  logic [7:0] r_rxShift;
  logic [7:0] r_rxData;
  logic       r_done;
  logic       r_cs;
  logic       w_ie;

  logic       w_dataWr;
  logic       w_dataRd;
  logic       w_ctrlWr;
  logic       w_divWr;
  logic       w_busy;
  logic       w_start;
  logic       w_toggle;
  logic       w_rise;
  logic       w_fall;
  logic       w_lastFall;

  assign w_dataWr   = io_write && (io_addr == ADDR_DATA);
  assign w_dataRd   = io_read  && (io_addr == ADDR_DATA);
  assign w_ctrlWr   = io_write && (io_addr == ADDR_CTRL);
  assign w_divWr    = io_write && (io_addr == ADDR_DIV);
  assign w_busy     = (r_state == ST_SHIFT);
  assign w_start    = w_dataWr && !w_busy;
  assign w_toggle   = w_busy && (r_cnt == 8'd0);
  assign w_rise     = w_toggle && !r_sclk;
  assign w_fall     = w_toggle && r_sclk;
  assign w_lastFall = w_fall && (r_bitCnt == 3'd7);

  // State register: the transfer FSM, aborted immediately by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state: start on a DATA write while idle, finish on the 8th falling edge.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_dataWr) begin
          w_nextState = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_lastFall) begin
          w_nextState = ST_IDLE;
        end
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // Half-period counter, SCLK and falling-edge count; the reload reads the live
  // divider so a DIV write during a transfer applies from the next reload.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= 8'd0;
      r_sclk   <= 1'b0;
      r_bitCnt <= 3'd0;
    end else if (w_start) begin
      r_cnt    <= r_div;
      r_sclk   <= 1'b0;
      r_bitCnt <= 3'd0;
    end else if (w_busy) begin
      if (r_cnt == 8'd0) begin
        r_cnt  <= r_div;
        r_sclk <= ~r_sclk;
        if (r_sclk) begin
          r_bitCnt <= r_bitCnt + 3'd1;
        end
      end else begin
        r_cnt <= r_cnt - 8'd1;
      end
    end
  end

  // Transmit shifter: loaded on start, shifted left on each falling edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx <= 8'hFF;
    end else if (w_start) begin
      r_tx <= io_wdata;
    end else if (w_fall) begin
      r_tx <= {r_tx[6:0], 1'b1};
    end
  end

  // Receive shifter: MISO enters the LSB on each rising edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rxShift <= 8'h00;
    end else if (w_start) begin
      r_rxShift <= 8'h00;
    end else if (w_rise) begin
      r_rxShift <= {r_rxShift[6:0], miso};
    end
  end

  // Received byte: only updated when a transfer completes, held otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rxData <= 8'h00;
    end else if (w_lastFall) begin
      r_rxData <= r_rxShift;
    end
  end

  // Done flag: setting on completion wins over a same-cycle DATA read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_done <= 1'b0;
    end else if (w_lastFall) begin
      r_done <= 1'b1;
    end else if (w_start || w_dataRd) begin
      r_done <= 1'b0;
    end
  end

  // Chip select and divider registers written from the bus.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cs  <= 1'b0;
      r_div <= RESET_DIV;
    end else begin
      if (w_ctrlWr) begin
        r_cs <= io_wdata[3];
      end
      if (w_divWr) begin
        r_div <= io_wdata;
      end
    end
  end

`ifdef SD_SPI_IRQ_EN
  logic r_ie;

  // Interrupt enable, writable at CTRL[2].
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ie <= 1'b0;
    end else if (w_ctrlWr) begin
      r_ie <= io_wdata[2];
    end
  end

  assign w_ie      = r_ie;
  assign interrupt = r_done & r_ie;
`else
  assign w_ie      = 1'b0;
  assign interrupt = 1'b0;
`endif

  // Combinational read mux; unmapped addresses read zero.
  always_comb begin
    io_rdata = 8'h00;
    case (io_addr)
      ADDR_DATA: io_rdata = r_rxData;
      ADDR_CTRL: io_rdata = {4'b0000, r_cs, w_ie, r_done, w_busy};
      ADDR_DIV:  io_rdata = r_div;
      default:   io_rdata = 8'h00;
    endcase
  end

  assign sclk = r_sclk;
  assign mosi = w_busy ? r_tx[7] : 1'b1;
  assign cs_n = ~r_cs;

endmodule

// File: tb/tb_sd_spi.sv
// Self-checking bench for sd_spi: directed and randomized transfers checked
// against a byte-level model (duration, bit order, received byte, flags).
module tb_sd_spi;

`ifdef SD_SPI_IRQ_EN
  localparam bit IRQ_BUILD = 1'b1;
`else
  localparam bit IRQ_BUILD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] io_addr;
  logic       io_write;
  logic       io_read;
  logic [7:0] io_wdata;
  logic [7:0] io_rdata;
  logic       interrupt;
  logic       sclk;
  logic       mosi;
  logic       cs_n;
  logic       miso;

  int         vectors = 0;
  int         miscompares = 0;
  int         riseCount = 0;
  int         riseBase = 0;
  int         misoIdx;
  logic       misoBit;
  longint     riseTime [64];
  logic       riseMosi [64];
  logic [7:0] misoByte = 8'hFF;
  logic [7:0] lastRx = 8'h00;

  sd_spi dut (
    .clk      (clk),
    .reset    (reset),
    .io_addr  (io_addr),
    .io_write (io_write),
    .io_read  (io_read),
    .io_wdata (io_wdata),
    .io_rdata (io_rdata),
    .interrupt(interrupt),
    .sclk     (sclk),
    .mosi     (mosi),
    .cs_n     (cs_n),
    .miso     (miso)
  );

  // Free-running system clock.
  always #5 clk = ~clk;

  // Record time and MOSI level at every SCLK rising edge.
  always @(posedge sclk) begin
    riseTime[riseCount % 64] = $time;
    riseMosi[riseCount % 64] = mosi;
    riseCount = riseCount + 1;
  end

  // Slave model: presents the next bit of misoByte, MSB first, before each rising edge.
  always_comb begin
    misoIdx = riseCount - riseBase;
    misoBit = 1'b1;
    if (misoIdx >= 0 && misoIdx < 8) begin
      misoBit = misoByte[3'(7 - misoIdx)];
    end
  end

  assign miso = misoBit;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One bus cycle starting at a falling clock edge; returns at the next falling edge.
  task automatic applyStimulus(input logic [3:0] addr, input logic [7:0] data, input bit isWrite);
    io_addr  = addr;
    io_wdata = data;
    io_write = isWrite;
    io_read  = !isWrite;
    @(negedge clk);
    io_write = 1'b0;
    io_read  = 1'b0;
  endtask

  // Look at a register without a read strobe (no side effects).
  task automatic peekReg(input logic [3:0] addr, output logic [7:0] val);
    io_addr = addr;
    #1;
    val = io_rdata;
  endtask

  // Total transfer length when DIV changes from oldDiv to newDiv at writeEdge
  // (clocks counted from the starting edge): each half-period lasts div+1
  // clocks, using the divider in force at the toggle that begins it.
  function automatic int spanWithDivChange(input int oldDiv, input int newDiv, input int writeEdge);
    int t;
    t = oldDiv + 1;
    for (int k = 2; k <= 16; k++) begin
      t = t + ((writeEdge < t) ? newDiv : oldDiv) + 1;
    end
    return t;
  endfunction

  task automatic runTransfer(input logic [7:0] txByte, input logic [7:0] misoVal,
                             input int expCycles, input int expHalf,
                             input int injectAt, input logic [3:0] injectAddr,
                             input logic [7:0] injectData, input bit readOnLast,
                             input bit leaveDone, input bit ieSet);
    logic [7:0] v;
    int         cycles;
    bit         ieExp;
    ieExp    = IRQ_BUILD && ieSet;
    misoByte = misoVal;
    riseBase = riseCount;
    applyStimulus(4'd0, txByte, 1'b1);
    peekReg(4'd1, v);
    checkOutput("busyRiseDoneClear", 32'(v[1:0]), 32'h1);
    checkOutput("csDuringXfer", 32'(cs_n), 32'h0);
    cycles = 0;
    while (cycles < 4000) begin
      io_write = 1'b0;
      io_read  = 1'b0;
      peekReg(4'd1, v);
      if (!v[0]) break;
      cycles++;
      if (cycles == 2) begin
        peekReg(4'd0, v);
        checkOutput("rxHeldDuringXfer", 32'(v), 32'(lastRx));
      end
      if (cycles == injectAt) begin
        io_addr  = injectAddr;
        io_wdata = injectData;
        io_write = 1'b1;
      end
      if (readOnLast && cycles == expCycles) begin
        peekReg(4'd0, v);
        checkOutput("readOnDoneCycle", 32'(v), 32'(lastRx));
        io_read = 1'b1;
      end
      @(negedge clk);
    end
    io_write = 1'b0;
    io_read  = 1'b0;
    checkOutput("spanClocks", 32'(cycles), 32'(expCycles));
    checkOutput("risingEdges", 32'(riseCount - riseBase), 32'd8);
    for (int i = 0; i < 8; i++) begin
      checkOutput("mosiBit", 32'(riseMosi[(riseBase + i) % 64]), 32'((txByte >> (7 - i)) & 8'h01));
    end
    if (expHalf > 0) begin
      for (int i = 0; i < 7; i++) begin
        checkOutput("sclkPeriod",
                    32'(riseTime[(riseBase + i + 1) % 64] - riseTime[(riseBase + i) % 64]),
                    32'(2 * expHalf * 10));
      end
    end
    peekReg(4'd1, v);
    checkOutput("doneStatus", 32'(v), 32'({4'b0000, 1'b1, ieExp, 2'b10}));
    checkOutput("irqOnDone", 32'(interrupt), 32'(ieExp));
    checkOutput("sclkIdle", 32'(sclk), 32'h0);
    checkOutput("mosiIdle", 32'(mosi), 32'h1);
    peekReg(4'd0, v);
    checkOutput("rxByte", 32'(v), 32'(misoVal));
    lastRx = misoVal;
    if (!leaveDone) begin
      applyStimulus(4'd0, 8'h00, 1'b0);
      peekReg(4'd1, v);
      checkOutput("doneClearedByRead", 32'(v[1]), 32'h0);
      checkOutput("irqClearedByRead", 32'(interrupt), 32'h0);
    end
  endtask

  initial begin
    logic [7:0] v;
    int         div;
    bit         ie;
    reset    = 1'b1;
    io_addr  = 4'd0;
    io_write = 1'b0;
    io_read  = 1'b0;
    io_wdata = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] reset state");
    peekReg(4'd1, v);
    checkOutput("rstCtrl", 32'(v), 32'h00);
    peekReg(4'd2, v);
    checkOutput("rstDiv", 32'(v), 32'd63);
    peekReg(4'd0, v);
    checkOutput("rstData", 32'(v), 32'h00);
    checkOutput("rstCsN", 32'(cs_n), 32'h1);
    checkOutput("rstSclk", 32'(sclk), 32'h0);
    checkOutput("rstMosi", 32'(mosi), 32'h1);
    checkOutput("rstIrq", 32'(interrupt), 32'h0);

    $display("[TB] unmapped address");
    applyStimulus(4'd5, 8'hAA, 1'b1);
    peekReg(4'd5, v);
    checkOutput("unmappedRead", 32'(v), 32'h00);
    peekReg(4'd2, v);
    checkOutput("unmappedNoDivEffect", 32'(v), 32'd63);

    $display("[TB] DIV=0 A5 with 3C returned");
    applyStimulus(4'd2, 8'd0, 1'b1);
    applyStimulus(4'd1, 8'h08, 1'b1);
    peekReg(4'd1, v);
    checkOutput("ctrlCsSet", 32'(v), 32'h08);
    checkOutput("csNLow", 32'(cs_n), 32'h0);
    runTransfer(8'hA5, 8'h3C, 16, 1, 0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0);

    $display("[TB] DIV=2 FF with write during busy");
    applyStimulus(4'd2, 8'd2, 1'b1);
    runTransfer(8'hFF, 8'($urandom), 48, 3, 10, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0);

    $display("[TB] interrupt enable");
    applyStimulus(4'd1, 8'h0C, 1'b1);
    peekReg(4'd1, v);
    checkOutput("ctrlIeRead", 32'(v), IRQ_BUILD ? 32'h0C : 32'h08);
    runTransfer(8'h55, 8'($urandom), 48, 3, 0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b1);

    $display("[TB] read on done-set cycle");
    applyStimulus(4'd2, 8'd1, 1'b1);
    runTransfer(8'($urandom), 8'($urandom), 32, 2, 0, 4'd0, 8'h00, 1'b1, 1'b0, 1'b1);

    $display("[TB] new transfer while done set");
    runTransfer(8'($urandom), 8'($urandom), 32, 2, 0, 4'd0, 8'h00, 1'b0, 1'b1, 1'b1);
    runTransfer(8'($urandom), 8'($urandom), 32, 2, 0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b1);

    $display("[TB] divider change mid-transfer");
    applyStimulus(4'd2, 8'd4, 1'b1);
    runTransfer(8'($urandom), 8'($urandom), spanWithDivChange(4, 1, 12), 0, 12, 4'd2, 8'd1,
                1'b0, 1'b0, 1'b1);
    peekReg(4'd2, v);
    checkOutput("divAfterChange", 32'(v), 32'd1);

    $display("[TB] randomized transfers");
    for (int n = 0; n < 6; n++) begin
      div = int'($urandom_range(0, 3));
      ie  = 1'($urandom_range(0, 1));
      applyStimulus(4'd2, 8'(div), 1'b1);
      applyStimulus(4'd1, {4'b0000, 1'b1, ie, 2'b00}, 1'b1);
      peekReg(4'd2, v);
      checkOutput("divReadback", 32'(v), 32'(div));
      runTransfer(8'($urandom), 8'($urandom), 16 * (div + 1), div + 1, 0, 4'd0, 8'h00,
                  1'b0, 1'b0, ie);
    end

    $display("[TB] reset mid-transfer");
    applyStimulus(4'd2, 8'd0, 1'b1);
    applyStimulus(4'd1, 8'h0C, 1'b1);
    riseBase = riseCount;
    misoByte = 8'h00;
    applyStimulus(4'd0, 8'hA5, 1'b1);
    repeat (4) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("abortSclk", 32'(sclk), 32'h0);
    checkOutput("abortCsN", 32'(cs_n), 32'h1);
    checkOutput("abortMosi", 32'(mosi), 32'h1);
    checkOutput("abortIrq", 32'(interrupt), 32'h0);
    peekReg(4'd1, v);
    checkOutput("abortCtrl", 32'(v), 32'h00);
    peekReg(4'd2, v);
    checkOutput("abortDiv", 32'(v), 32'd63);
    lastRx = 8'h00;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    peekReg(4'd0, v);
    checkOutput("abortRxCleared", 32'(v), 32'h00);

    $display("[TB] clean transfer after reset");
    applyStimulus(4'd2, 8'd0, 1'b1);
    applyStimulus(4'd1, 8'h08, 1'b1);
    runTransfer(8'($urandom), 8'($urandom), 16, 1, 0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
